// File: rtl/rotary_encoder_multi_if.sv
// Pad-side and status bundle for rotary_encoder_multi: quadrature pins and clears in,
// detent/error pulses and packed signed positions out.
interface rotary_encoder_multi_if #(
   parameter int CHANNELS  = 1,
   parameter int POS_WIDTH = 16
);
   logic [CHANNELS-1:0]           in_a;
   logic [CHANNELS-1:0]           in_b;
   logic [CHANNELS-1:0]           clear;
   logic [CHANNELS-1:0]           out_cw;
   logic [CHANNELS-1:0]           out_ccw;
   logic [CHANNELS-1:0]           out_err;
   logic [CHANNELS*POS_WIDTH-1:0] position;

   modport master (
      output in_a, in_b, clear,
      input  out_cw, out_ccw, out_err, position
   );

   modport slave (
      input  in_a, in_b, clear,
      output out_cw, out_ccw, out_err, position
   );
endinterface

// File: rtl/pullup_input.sv
// Encoder pin input stage. The weak pull-up itself is a pad-ring cell; logically the
// pin is passed straight through so an unconnected encoder idles high at the pad.
module pullup_input (
   input  logic pad_i,
   output logic pin_o
);
   assign pin_o = pad_i;
endmodule

// File: rtl/rotary_encoder_multi.sv
// N-channel quadrature decoder: per-channel 2-flop synchroniser, debounce, Gray-code
// decode with illegal-transition flag, sub-step accumulation and a signed position counter.
module rotary_encoder_multi #(
   parameter int CHANNELS         = 1,
   parameter int DEBOUNCE_CYCLES  = 0,
   parameter int STEPS_PER_DETENT = 4,
   parameter int POS_WIDTH        = 16,
   parameter int WRAP             = 1,
   parameter int USE_PULLUP       = 1
) (
   input logic                   clk,
   input logic                   rst,
   rotary_encoder_multi_if.slave bus
);
   localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0]            CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]            CNT_ONE = CNT_W'(1);
   localparam logic signed [3:0]           SUB_MAX = 4'(STEPS_PER_DETENT);
   localparam logic signed [3:0]           SUB_MIN = -SUB_MAX;
   localparam logic signed [POS_WIDTH-1:0] POS_MAX = {1'b0, {(POS_WIDTH-1){1'b1}}};
   localparam logic signed [POS_WIDTH-1:0] POS_MIN = {1'b1, {(POS_WIDTH-1){1'b0}}};
   localparam logic signed [POS_WIDTH-1:0] POS_ONE = {{(POS_WIDTH-1){1'b0}}, 1'b1};

   // Position of an {a,b} pair along the clockwise cycle 11 -> 01 -> 00 -> 10.
   function automatic logic [1:0] phase_idx(input logic [1:0] ab);
      case (ab)
         2'b11:   phase_idx = 2'd0;
         2'b01:   phase_idx = 2'd1;
         2'b00:   phase_idx = 2'd2;
         default: phase_idx = 2'd3;
      endcase
   endfunction

   logic [CHANNELS-1:0]           pin_a_s, pin_b_s;
   logic [CHANNELS-1:0]           cw_s, ccw_s, err_s;
   logic [CHANNELS*POS_WIDTH-1:0] pos_s;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      if (USE_PULLUP != 0) begin : g_pu
         pullup_input u_pu_a (.pad_i(bus.in_a[i]), .pin_o(pin_a_s[i]));
         pullup_input u_pu_b (.pad_i(bus.in_b[i]), .pin_o(pin_b_s[i]));
      end else begin : g_nopu
         assign pin_a_s[i] = bus.in_a[i];
         assign pin_b_s[i] = bus.in_b[i];
      end

      logic [1:0]                  sync1_q, sync1_d, sync2_q, sync2_d;
      logic [1:0]                  deb_q, deb_d, prev_q, prev_d;
      logic [CNT_W-1:0]            cnt_q, cnt_d;
      logic signed [3:0]           sub_q, sub_d, sub_sum_s;
      logic signed [POS_WIDTH-1:0] pos_q, pos_d;
      logic                        cw_q, cw_d, ccw_q, ccw_d, err_q, err_d;
      logic [1:0]                  step_s;

      always_ff @(posedge clk) begin
         if (rst) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            deb_q   <= 2'b11;
            prev_q  <= 2'b11;
            cnt_q   <= {CNT_W{1'b0}};
            sub_q   <= 4'sd0;
            pos_q   <= {POS_WIDTH{1'b0}};
            cw_q    <= 1'b0;
            ccw_q   <= 1'b0;
            err_q   <= 1'b0;
         end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            sub_q   <= sub_d;
            pos_q   <= pos_d;
            cw_q    <= cw_d;
            ccw_q   <= ccw_d;
            err_q   <= err_d;
         end
      end

      always_comb begin
         sync1_d   = {pin_a_s[i], pin_b_s[i]};
         sync2_d   = sync1_q;
         deb_d     = deb_q;
         cnt_d     = {CNT_W{1'b0}};
         prev_d    = deb_q;
         cw_d      = 1'b0;
         ccw_d     = 1'b0;
         err_d     = 1'b0;
         sub_sum_s = sub_q;
         sub_d     = sub_q;
         pos_d     = pos_q;

         // A pair that keeps moving still counts; whatever is present at the limit wins.
         if (sync2_q != deb_q) begin
            if (cnt_q == CNT_MAX) begin
               deb_d = sync2_q;
               cnt_d = {CNT_W{1'b0}};
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end else begin
            cnt_d = {CNT_W{1'b0}};
         end

         step_s = phase_idx(deb_q) - phase_idx(prev_q);
         case (step_s)
            2'd0:    sub_sum_s = sub_q;
            2'd1:    sub_sum_s = sub_q + 4'sd1;
            2'd3:    sub_sum_s = sub_q - 4'sd1;
            default: err_d     = 1'b1;
         endcase

         if (sub_sum_s == SUB_MAX) begin
            cw_d  = 1'b1;
            sub_d = 4'sd0;
            if ((WRAP != 0) || (pos_q != POS_MAX)) begin
               pos_d = pos_q + POS_ONE;
            end else begin
               pos_d = pos_q;
            end
         end else if (sub_sum_s == SUB_MIN) begin
            ccw_d = 1'b1;
            sub_d = 4'sd0;
            if ((WRAP != 0) || (pos_q != POS_MIN)) begin
               pos_d = pos_q - POS_ONE;
            end else begin
               pos_d = pos_q;
            end
         end else begin
            sub_d = sub_sum_s;
         end

         // Clear wins over a same-cycle detent, but the detent pulse is still reported.
         if (bus.clear[i]) begin
            pos_d = {POS_WIDTH{1'b0}};
            sub_d = 4'sd0;
         end else begin
            pos_d = pos_d;
         end
      end

      assign cw_s[i]                          = cw_q;
      assign ccw_s[i]                         = ccw_q;
      assign err_s[i]                         = err_q;
      assign pos_s[i*POS_WIDTH +: POS_WIDTH]  = pos_q;
   end

   assign bus.out_cw   = cw_s;
   assign bus.out_ccw  = ccw_s;
   assign bus.out_err  = err_s;
   assign bus.position = pos_s;
endmodule

// File: tb/tb_rotary_encoder_multi.sv
// Directed bench for rotary_encoder_multi: four instances cover the default decoder,
// a debounced channel, and saturating vs wrapping position counters.
module tb_rotary_encoder_multi;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rotary_encoder_multi_if #(.CHANNELS(2), .POS_WIDTH(16)) main_if ();
   rotary_encoder_multi_if #(.CHANNELS(1), .POS_WIDTH(16)) deb_if ();
   rotary_encoder_multi_if #(.CHANNELS(1), .POS_WIDTH(16)) sat_if ();
   rotary_encoder_multi_if #(.CHANNELS(1), .POS_WIDTH(16)) wrap_if ();

   rotary_encoder_multi #(.CHANNELS(2), .DEBOUNCE_CYCLES(0), .STEPS_PER_DETENT(4),
      .POS_WIDTH(16), .WRAP(1), .USE_PULLUP(1)) u_main (.clk(clk), .rst(rst), .bus(main_if));
   rotary_encoder_multi #(.CHANNELS(1), .DEBOUNCE_CYCLES(5), .STEPS_PER_DETENT(4),
      .POS_WIDTH(16), .WRAP(1), .USE_PULLUP(0)) u_deb (.clk(clk), .rst(rst), .bus(deb_if));
   rotary_encoder_multi #(.CHANNELS(1), .DEBOUNCE_CYCLES(0), .STEPS_PER_DETENT(1),
      .POS_WIDTH(16), .WRAP(0), .USE_PULLUP(1)) u_sat (.clk(clk), .rst(rst), .bus(sat_if));
   rotary_encoder_multi #(.CHANNELS(1), .DEBOUNCE_CYCLES(0), .STEPS_PER_DETENT(1),
      .POS_WIDTH(16), .WRAP(1), .USE_PULLUP(1)) u_wrap (.clk(clk), .rst(rst), .bus(wrap_if));

   int pass_cnt  = 0;
   int total_cnt = 0;
   int main_cw0 = 0, main_cw1 = 0, main_err0 = 0, main_err1 = 0;
   int deb_cw = 0, deb_ccw = 0, deb_err = 0, sat_cw = 0, wrap_cw = 0;
   int cw_snap;
   logic [1:0] seq [4] = '{2'b11, 2'b01, 2'b00, 2'b10};

   // Pulse tallies sampled on the inactive edge.
   always @(negedge clk) begin
      if (main_if.out_cw[0])  main_cw0  <= main_cw0 + 1;
      if (main_if.out_cw[1])  main_cw1  <= main_cw1 + 1;
      if (main_if.out_err[0]) main_err0 <= main_err0 + 1;
      if (main_if.out_err[1]) main_err1 <= main_err1 + 1;
      if (deb_if.out_cw[0])   deb_cw    <= deb_cw + 1;
      if (deb_if.out_ccw[0])  deb_ccw   <= deb_ccw + 1;
      if (deb_if.out_err[0])  deb_err   <= deb_err + 1;
      if (sat_if.out_cw[0])   sat_cw    <= sat_cw + 1;
      if (wrap_if.out_cw[0])  wrap_cw   <= wrap_cw + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      if (obs === exp) pass_cnt++;
      else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_main(input int ch, input logic [1:0] ab);
      main_if.in_a[ch] = ab[1];
      main_if.in_b[ch] = ab[0];
   endtask

   task automatic set_deb(input logic [1:0] ab);
      deb_if.in_a[0] = ab[1];
      deb_if.in_b[0] = ab[0];
   endtask

   task automatic set_lim(input logic [1:0] ab);
      sat_if.in_a[0]  = ab[1];
      sat_if.in_b[0]  = ab[0];
      wrap_if.in_a[0] = ab[1];
      wrap_if.in_b[0] = ab[0];
   endtask

   initial begin
      rst = 1'b1;
      main_if.in_a = 2'b11; main_if.in_b = 2'b11; main_if.clear = 2'b00;
      deb_if.in_a = 1'b1;   deb_if.in_b = 1'b1;   deb_if.clear = 1'b0;
      sat_if.in_a = 1'b1;   sat_if.in_b = 1'b1;   sat_if.clear = 1'b0;
      wrap_if.in_a = 1'b1;  wrap_if.in_b = 1'b1;  wrap_if.clear = 1'b0;
      tick(4);
      rst = 1'b0;
      tick(2);
      check("rst_cw",   32'(main_if.out_cw),   32'd0);
      check("rst_ccw",  32'(main_if.out_ccw),  32'd0);
      check("rst_err",  32'(main_if.out_err),  32'd0);
      check("rst_pos",  main_if.position,      32'd0);
      check("rst_deb_pos", 32'(deb_if.position), 32'd0);

      // Channel 0 clockwise detent, no debounce.
      set_main(0, 2'b01); tick(10);
      set_main(0, 2'b00); tick(10);
      set_main(0, 2'b10); tick(10);
      check("cw_mid_pos", 32'(main_if.position[15:0]), 32'd0);
      check("cw_mid_cnt", 32'(main_cw0), 32'd0);
      set_main(0, 2'b11); tick(3);
      check("cw_early", 32'(main_if.out_cw), 32'd0);
      tick(1);
      check("cw_pulse", 32'(main_if.out_cw), 32'd1);
      check("cw_pos",   32'(main_if.position[15:0]), 32'd1);
      tick(1);
      check("cw_one_clk", 32'(main_if.out_cw), 32'd0);
      check("cw_cnt",     32'(main_cw0), 32'd1);
      check("cw_ch1_pos", 32'(main_if.position[31:16]), 32'd0);
      check("cw_ch1_cnt", 32'(main_cw1), 32'd0);

      // Debounced channel: 2-clk glitch rejected, then counter-clockwise detent.
      set_deb(2'b01); tick(2);
      set_deb(2'b11); tick(20);
      check("glitch_evt", 32'(deb_cw + deb_ccw + deb_err), 32'd0);
      check("glitch_pos", 32'(deb_if.position), 32'd0);
      set_deb(2'b10); tick(12);
      set_deb(2'b00); tick(12);
      set_deb(2'b01); tick(12);
      set_deb(2'b11); tick(8);
      check("deb_early", 32'(deb_if.out_ccw), 32'd0);
      tick(1);
      check("deb_ccw_pulse", 32'(deb_if.out_ccw), 32'd1);
      check("deb_pos", 32'(deb_if.position), 32'h0000FFFF);
      tick(2);
      check("deb_ccw_cnt", 32'(deb_ccw), 32'd1);
      check("deb_cw_cnt",  32'(deb_cw),  32'd0);

      // Channel 1 illegal jump, then partial rotation, then completion.
      set_main(1, 2'b00); tick(4);
      check("err_pulse", 32'(main_if.out_err), 32'd2);
      tick(1);
      check("err_one_clk", 32'(main_if.out_err), 32'd0);
      check("err_pos", 32'(main_if.position[31:16]), 32'd0);
      set_main(1, 2'b10); tick(10);
      set_main(1, 2'b11); tick(10);
      check("sub2_cw_cnt", 32'(main_cw1), 32'd0);
      check("sub2_pos",    32'(main_if.position[31:16]), 32'd0);
      check("err_cnt",     32'(main_err1), 32'd1);
      set_main(1, 2'b01); tick(10);
      set_main(1, 2'b00); tick(10);
      check("sub4_cw_cnt", 32'(main_cw1), 32'd1);
      check("sub4_pos",    32'(main_if.position[31:16]), 32'd1);
      set_main(1, 2'b10); tick(10);
      set_main(1, 2'b11); tick(10);

      // Saturate vs wrap, one detent per transition.
      for (int i = 1; i <= 32767; i++) begin
         set_lim(seq[i % 4]);
         tick(1);
      end
      tick(5);
      check("sat_max",  32'(sat_if.position),  32'h00007FFF);
      check("wrap_max", 32'(wrap_if.position), 32'h00007FFF);
      set_lim(seq[0]);
      tick(5);
      check("sat_hold",   32'(sat_if.position),  32'h00007FFF);
      check("wrap_over",  32'(wrap_if.position), 32'h00008000);
      check("sat_pulses", 32'(sat_cw),  32'd32768);
      check("wrap_pulses", 32'(wrap_cw), 32'd32768);

      // Clear coinciding with a detent on channel 0.
      set_main(0, 2'b01); tick(10);
      set_main(0, 2'b00); tick(10);
      set_main(0, 2'b10); tick(10);
      set_main(0, 2'b11); tick(3);
      main_if.clear[0] = 1'b1;
      tick(1);
      main_if.clear[0] = 1'b0;
      check("clr_pulse", 32'(main_if.out_cw), 32'd1);
      check("clr_pos",   32'(main_if.position[15:0]), 32'd0);
      check("clr_err",   32'(main_if.out_err), 32'd0);
      tick(1);
      check("clr_hold",  32'(main_if.position[15:0]), 32'd0);

      // Reset after two sub-steps discards them.
      set_main(0, 2'b01); tick(10);
      set_main(0, 2'b00); tick(10);
      rst = 1'b1;
      set_main(0, 2'b11);
      tick(5);
      rst = 1'b0;
      tick(5);
      cw_snap = main_cw0;
      check("rst2_pos", main_if.position, 32'd0);
      set_main(0, 2'b01); tick(10);
      set_main(0, 2'b00); tick(10);
      check("rst2_half_pos", 32'(main_if.position[15:0]), 32'd0);
      set_main(0, 2'b10); tick(10);
      set_main(0, 2'b11); tick(10);
      check("rst2_full_pos", 32'(main_if.position[15:0]), 32'd1);
      check("rst2_detents",  32'(main_cw0 - cw_snap), 32'd1);
      check("ch0_err_cnt",   32'(main_err0), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
